// File: rtl/ahb_mtx_out_stage.sv
// AHB matrix output stage: arbitrates three input-stage decoder channels onto one
// AHB-Lite slave port, with round-robin/fixed priority and burst/lock grant hold.
//
// state | meaning
// OPEN  | hold = 0, grant follows the arbiter every completing cycle
// HELD  | hold = 1, grant pinned to hold_port for a burst or locked sequence
module ahb_mtx_out_stage #(
   parameter int DATA_WIDTH   = 32,
   parameter int MASTER_WIDTH = 4,
   parameter bit RR_EN        = 1'b1
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    sel_op0,
   input  logic                    sel_op1,
   input  logic                    sel_op2,
   input  logic [31:0]             addr_op0,
   input  logic [31:0]             addr_op1,
   input  logic [31:0]             addr_op2,
   input  logic [1:0]              trans_op0,
   input  logic [1:0]              trans_op1,
   input  logic [1:0]              trans_op2,
   input  logic                    write_op0,
   input  logic                    write_op1,
   input  logic                    write_op2,
   input  logic [2:0]              size_op0,
   input  logic [2:0]              size_op1,
   input  logic [2:0]              size_op2,
   input  logic [2:0]              burst_op0,
   input  logic [2:0]              burst_op1,
   input  logic [2:0]              burst_op2,
   input  logic [3:0]              prot_op0,
   input  logic [3:0]              prot_op1,
   input  logic [3:0]              prot_op2,
   input  logic [MASTER_WIDTH-1:0] master_op0,
   input  logic [MASTER_WIDTH-1:0] master_op1,
   input  logic [MASTER_WIDTH-1:0] master_op2,
   input  logic                    mastlock_op0,
   input  logic                    mastlock_op1,
   input  logic                    mastlock_op2,
   input  logic [DATA_WIDTH-1:0]   wdata_op0,
   input  logic [DATA_WIDTH-1:0]   wdata_op1,
   input  logic [DATA_WIDTH-1:0]   wdata_op2,
   output logic                    active_op0,
   output logic                    active_op1,
   output logic                    active_op2,
   input  logic                    HREADYOUTM,
   input  logic                    HRESPM,
   output logic                    HSELM,
   output logic [31:0]             HADDRM,
   output logic [1:0]              HTRANSM,
   output logic                    HWRITEM,
   output logic [2:0]              HSIZEM,
   output logic [2:0]              HBURSTM,
   output logic [3:0]              HPROTM,
   output logic [MASTER_WIDTH-1:0] HMASTERM,
   output logic                    HMASTLOCKM,
   output logic [DATA_WIDTH-1:0]   HWDATAM,
   output logic                    HREADYMUXM
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_SINGLE = 3'b000;

   logic [2:0]              sel_v;
   logic [2:0]              write_v;
   logic [2:0]              lock_v;
   logic [2:0]              req_v;
   logic [31:0]             addr_a   [3];
   logic [1:0]              trans_a  [3];
   logic [2:0]              size_a   [3];
   logic [2:0]              burst_a  [3];
   logic [3:0]              prot_a   [3];
   logic [MASTER_WIDTH-1:0] master_a [3];
   logic [DATA_WIDTH-1:0]   wdata_a  [3];

   logic [1:0] last_port, last_port_nxt;
   logic       hold, hold_nxt;
   logic [1:0] hold_port, hold_port_nxt;
   logic [1:0] data_port, data_port_nxt;
   logic       data_vld, data_vld_nxt;

   logic [1:0] addr_port;
   logic       addr_vld;
   logic [1:0] scan1, scan2, scan3;
   logic       hold_set, hold_keep;

   assign sel_v   = {sel_op2, sel_op1, sel_op0};
   assign write_v = {write_op2, write_op1, write_op0};
   assign lock_v  = {mastlock_op2, mastlock_op1, mastlock_op0};
   assign addr_a   = '{addr_op0, addr_op1, addr_op2};
   assign trans_a  = '{trans_op0, trans_op1, trans_op2};
   assign size_a   = '{size_op0, size_op1, size_op2};
   assign burst_a  = '{burst_op0, burst_op1, burst_op2};
   assign prot_a   = '{prot_op0, prot_op1, prot_op2};
   assign master_a = '{master_op0, master_op1, master_op2};
   assign wdata_a  = '{wdata_op0, wdata_op1, wdata_op2};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req_v[i] = sel_v[i] & (trans_a[i] != TR_IDLE);
      end
   end

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Arbiter: zero-latency, so the decoder sees active in the same cycle it requests.
   always_comb begin
      addr_port = 2'd0;
      addr_vld  = 1'b0;
      scan1     = next_port(last_port);
      scan2     = next_port(scan1);
      scan3     = next_port(scan2);
      if (hold) begin
         addr_port = hold_port;
         addr_vld  = 1'b1;
      end else if (RR_EN) begin
         if (req_v[scan1]) begin
            addr_port = scan1;
            addr_vld  = 1'b1;
         end else if (req_v[scan2]) begin
            addr_port = scan2;
            addr_vld  = 1'b1;
         end else if (req_v[scan3]) begin
            addr_port = scan3;
            addr_vld  = 1'b1;
         end
      end else begin
         if (req_v[0]) begin
            addr_port = 2'd0;
            addr_vld  = 1'b1;
         end else if (req_v[1]) begin
            addr_port = 2'd1;
            addr_vld  = 1'b1;
         end else if (req_v[2]) begin
            addr_port = 2'd2;
            addr_vld  = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_port <= 2'd2;
         hold      <= 1'b0;
         hold_port <= 2'd0;
         data_port <= 2'd0;
         data_vld  <= 1'b0;
      end else begin
         last_port <= last_port_nxt;
         hold      <= hold_nxt;
         hold_port <= hold_port_nxt;
         data_port <= data_port_nxt;
         data_vld  <= data_vld_nxt;
      end
   end

   // A locked IDLE keeps the grant; an unlocked IDLE, a SINGLE or a dropped sel releases it.
   assign hold_set  = (HMASTLOCKM & (HTRANSM != TR_IDLE)) |
                      ((HTRANSM == TR_NONSEQ) & (HBURSTM != BU_SINGLE));
   assign hold_keep = hold & HSELM & ((HTRANSM == TR_BUSY) | (HTRANSM == TR_SEQ) |
                      ((HTRANSM == TR_IDLE) & HMASTLOCKM));

   always_comb begin
      last_port_nxt = last_port;
      hold_nxt      = hold;
      hold_port_nxt = hold_port;
      data_port_nxt = data_port;
      data_vld_nxt  = data_vld;
      if (HREADYOUTM) begin
         data_vld_nxt = (HTRANSM != TR_IDLE);
         if (addr_vld) begin
            last_port_nxt = addr_port;
            data_port_nxt = addr_port;
            hold_nxt      = hold_set | hold_keep;
            if (hold_set) begin
               hold_port_nxt = addr_port;
            end
         end
      end
   end

   always_comb begin
      HSELM      = 1'b0;
      HADDRM     = '0;
      HTRANSM    = TR_IDLE;
      HWRITEM    = 1'b0;
      HSIZEM     = '0;
      HBURSTM    = '0;
      HPROTM     = '0;
      HMASTERM   = '0;
      HMASTLOCKM = 1'b0;
      if (addr_vld) begin
         HSELM      = sel_v[addr_port];
         HADDRM     = addr_a[addr_port];
         HTRANSM    = sel_v[addr_port] ? trans_a[addr_port] : TR_IDLE;
         HWRITEM    = write_v[addr_port];
         HSIZEM     = size_a[addr_port];
         HBURSTM    = burst_a[addr_port];
         HPROTM     = prot_a[addr_port];
         HMASTERM   = master_a[addr_port];
         HMASTLOCKM = lock_v[addr_port];
      end
      HWDATAM    = data_vld ? wdata_a[data_port] : '0;
      HREADYMUXM = HREADYOUTM;
      active_op0 = addr_vld & (addr_port == 2'd0);
      active_op1 = addr_vld & (addr_port == 2'd1);
      active_op2 = addr_vld & (addr_port == 2'd2);
   end

   logic unused_ok;
   assign unused_ok = HRESPM;

endmodule

// File: tb/tb_ahb_mtx_out_stage.sv
// Directed bench for ahb_mtx_out_stage: arbitration order, burst/lock hold,
// wait-state freeze and reset behaviour, with hand-computed expectations.
module tb_ahb_mtx_out_stage;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR4  = 3'b011;

   logic        HCLK;
   logic        HRESETn;
   logic        sel      [3];
   logic [31:0] addr     [3];
   logic [1:0]  trans    [3];
   logic        write    [3];
   logic [2:0]  size     [3];
   logic [2:0]  burst    [3];
   logic [3:0]  prot     [3];
   logic [3:0]  master   [3];
   logic        mlock    [3];
   logic [31:0] wdata    [3];
   logic        active_op0, active_op1, active_op2;
   logic        HREADYOUTM, HRESPM;
   logic        HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
   logic [31:0] HADDRM, HWDATAM;
   logic [1:0]  HTRANSM;
   logic [2:0]  HSIZEM, HBURSTM;
   logic [3:0]  HPROTM, HMASTERM;
   logic [2:0]  act;

   int checks = 0;
   int errors = 0;

   assign act = {active_op2, active_op1, active_op0};

   ahb_mtx_out_stage dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .sel_op0(sel[0]), .sel_op1(sel[1]), .sel_op2(sel[2]),
      .addr_op0(addr[0]), .addr_op1(addr[1]), .addr_op2(addr[2]),
      .trans_op0(trans[0]), .trans_op1(trans[1]), .trans_op2(trans[2]),
      .write_op0(write[0]), .write_op1(write[1]), .write_op2(write[2]),
      .size_op0(size[0]), .size_op1(size[1]), .size_op2(size[2]),
      .burst_op0(burst[0]), .burst_op1(burst[1]), .burst_op2(burst[2]),
      .prot_op0(prot[0]), .prot_op1(prot[1]), .prot_op2(prot[2]),
      .master_op0(master[0]), .master_op1(master[1]), .master_op2(master[2]),
      .mastlock_op0(mlock[0]), .mastlock_op1(mlock[1]), .mastlock_op2(mlock[2]),
      .wdata_op0(wdata[0]), .wdata_op1(wdata[1]), .wdata_op2(wdata[2]),
      .active_op0(active_op0), .active_op1(active_op1), .active_op2(active_op2),
      .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM),
      .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
      .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM), .HREADYMUXM(HREADYMUXM)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int p, input logic [1:0] t, input logic [2:0] b, input logic lk,
                      input logic [31:0] a, input logic [31:0] wd);
      sel[p]    = 1'b1;
      trans[p]  = t;
      burst[p]  = b;
      mlock[p]  = lk;
      addr[p]   = a;
      wdata[p]  = wd;
      write[p]  = 1'b1;
      size[p]   = 3'd2;
      prot[p]   = 4'd3;
      master[p] = p[3:0];
   endtask

   // Drops the request but leaves wdata, which still feeds an outstanding data phase.
   task automatic rel(input int p);
      sel[p]   = 1'b0;
      trans[p] = IDLE;
      mlock[p] = 1'b0;
   endtask

   task automatic tick;
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn    = 1'b0;
      HREADYOUTM = 1'b1;
      HRESPM     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(i, IDLE, SINGLE, 1'b0, 32'h0, 32'h0);
         rel(i);
      end
      #2;
      chk("rst_hsel", HSELM, 1'b0);
      chk("rst_htrans", HTRANSM, IDLE);
      chk("rst_active", act, 3'b000);
      chk("rst_hwdata", HWDATAM, 32'h0);
      tick;
      HRESETn = 1'b1;

      // single read from port 0
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h6004_0000, 32'h55);
      write[0] = 1'b0;
      @(negedge HCLK);
      chk("rd_htrans", HTRANSM, NONSEQ);
      chk("rd_haddr", HADDRM, 32'h6004_0000);
      chk("rd_active", act, 3'b001);
      chk("rd_hsel", HSELM, 1'b1);
      chk("rd_hwrite", HWRITEM, 1'b0);
      chk("rd_hready", HREADYMUXM, 1'b1);
      tick;
      rel(0);
      @(negedge HCLK);
      chk("rd_dphase", HWDATAM, 32'h55);
      chk("rd_idle_active", act, 3'b000);
      tick;

      // back-to-back single writes from all ports, after a fresh reset
      HRESETn = 1'b0;
      #1;
      tick;
      HRESETn = 1'b1;
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h1000, 32'hA0);
      drv(1, NONSEQ, SINGLE, 1'b0, 32'h1100, 32'hA1);
      drv(2, NONSEQ, SINGLE, 1'b0, 32'h1200, 32'hA2);
      @(negedge HCLK);
      chk("rr0_active", act, 3'b001);
      chk("rr0_hwdata", HWDATAM, 32'h0);
      tick;
      @(negedge HCLK);
      chk("rr1_active", act, 3'b010);
      chk("rr1_haddr", HADDRM, 32'h1100);
      chk("rr1_hmaster", HMASTERM, 4'd1);
      chk("rr1_hwdata", HWDATAM, 32'hA0);
      tick;
      @(negedge HCLK);
      chk("rr2_active", act, 3'b100);
      chk("rr2_hwdata", HWDATAM, 32'hA1);
      tick;
      @(negedge HCLK);
      chk("rr3_active", act, 3'b001);
      chk("rr3_hwdata", HWDATAM, 32'hA2);
      tick;
      for (int i = 0; i < 3; i++) rel(i);
      @(negedge HCLK);
      chk("rr4_hwdata", HWDATAM, 32'hA0);
      chk("rr4_hsel", HSELM, 1'b0);
      tick;

      // port 1 INCR4 with a BUSY beat, port 0 waiting
      drv(1, NONSEQ, INCR4, 1'b0, 32'h100, 32'h0);
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h200, 32'h0);
      @(negedge HCLK);
      chk("b_ns_active", act, 3'b010);
      chk("b_ns_hburst", HBURSTM, INCR4);
      tick;
      drv(1, SEQ, INCR4, 1'b0, 32'h104, 32'h0);
      @(negedge HCLK);
      chk("b_seq1_active", act, 3'b010);
      chk("b_seq1_haddr", HADDRM, 32'h104);
      tick;
      drv(1, BUSY, INCR4, 1'b0, 32'h108, 32'h0);
      @(negedge HCLK);
      chk("b_busy_active", act, 3'b010);
      chk("b_busy_htrans", HTRANSM, BUSY);
      tick;
      drv(1, SEQ, INCR4, 1'b0, 32'h108, 32'h0);
      @(negedge HCLK);
      chk("b_seq2_active", act, 3'b010);
      tick;
      drv(1, SEQ, INCR4, 1'b0, 32'h10C, 32'h0);
      @(negedge HCLK);
      chk("b_seq3_active", act, 3'b010);
      tick;
      drv(1, IDLE, SINGLE, 1'b0, 32'h110, 32'h0);
      @(negedge HCLK);
      chk("b_idle_active", act, 3'b010);
      chk("b_idle_htrans", HTRANSM, IDLE);
      tick;
      rel(1);
      @(negedge HCLK);
      chk("b_rel_active", act, 3'b001);
      chk("b_rel_haddr", HADDRM, 32'h200);
      tick;
      rel(0);

      // port 2 locked sequence across an IDLE, port 0 waiting
      drv(2, NONSEQ, SINGLE, 1'b1, 32'h300, 32'h0);
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h200, 32'h0);
      @(negedge HCLK);
      chk("lk1_active", act, 3'b100);
      chk("lk1_hmastlock", HMASTLOCKM, 1'b1);
      tick;
      drv(2, IDLE, SINGLE, 1'b1, 32'h300, 32'h0);
      @(negedge HCLK);
      chk("lk_idle_active", act, 3'b100);
      tick;
      drv(2, NONSEQ, SINGLE, 1'b1, 32'h304, 32'h0);
      @(negedge HCLK);
      chk("lk2_active", act, 3'b100);
      chk("lk2_haddr", HADDRM, 32'h304);
      tick;
      drv(2, IDLE, SINGLE, 1'b0, 32'h304, 32'h0);
      @(negedge HCLK);
      chk("lk_unlk_active", act, 3'b100);
      tick;
      rel(2);
      @(negedge HCLK);
      chk("lk_rel_active", act, 3'b001);
      tick;
      rel(0);

      // wait states while port 1 raises a request
      drv(2, NONSEQ, SINGLE, 1'b0, 32'h600, 32'hC2);
      @(negedge HCLK);
      chk("ws0_active", act, 3'b100);
      tick;
      rel(2);
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h400, 32'hB0);
      HREADYOUTM = 1'b0;
      @(negedge HCLK);
      chk("ws1_active", act, 3'b001);
      chk("ws1_hready", HREADYMUXM, 1'b0);
      chk("ws1_hwdata", HWDATAM, 32'hC2);
      tick;
      drv(1, NONSEQ, SINGLE, 1'b0, 32'h500, 32'hB1);
      for (int w = 0; w < 2; w++) begin
         @(negedge HCLK);
         chk("ws_active", act, 3'b001);
         chk("ws_haddr", HADDRM, 32'h400);
         chk("ws_hwdata", HWDATAM, 32'hC2);
         tick;
      end
      HREADYOUTM = 1'b1;
      @(negedge HCLK);
      chk("ws_done_active", act, 3'b001);
      chk("ws_done_hwdata", HWDATAM, 32'hC2);
      tick;
      rel(0);
      @(negedge HCLK);
      chk("ws_p1_active", act, 3'b010);
      chk("ws_p1_haddr", HADDRM, 32'h500);
      chk("ws_p1_hwdata", HWDATAM, 32'hB0);
      tick;
      rel(1);

      // reset in the middle of a port 1 INCR4
      drv(1, NONSEQ, INCR4, 1'b0, 32'h700, 32'h0);
      @(negedge HCLK);
      chk("rb_ns_active", act, 3'b010);
      tick;
      drv(1, SEQ, INCR4, 1'b0, 32'h704, 32'h0);
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h900, 32'h0);
      @(negedge HCLK);
      chk("rb_seq_active", act, 3'b010);
      HRESETn = 1'b0;
      rel(0);
      rel(1);
      #1;
      chk("rb_htrans", HTRANSM, IDLE);
      chk("rb_hsel", HSELM, 1'b0);
      chk("rb_active", act, 3'b000);
      chk("rb_hwdata", HWDATAM, 32'h0);
      tick;
      drv(0, NONSEQ, SINGLE, 1'b0, 32'h900, 32'h0);
      drv(1, NONSEQ, SINGLE, 1'b0, 32'h800, 32'h0);
      #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("ra_active", act, 3'b001);
      chk("ra_haddr", HADDRM, 32'h900);
      tick;
      @(negedge HCLK);
      chk("ra_next_active", act, 3'b010);
      chk("ra_next_haddr", HADDRM, 32'h800);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_mtx_out_stage.md
Name: ahb_mtx_out_stage

Overview:
- AHB matrix output stage: the far end of the matrix input-stage decoders.
- Receives address-phase requests from 3 input ports (decoders' sel/active channel) and arbitrates round-robin, with burst and lock hold.
- Drives one AHB-Lite slave port and returns per-port active grant signals.
- Read data/response return directly from the slave to the decoders and do not pass through this block.

Parameters:
- DATA_WIDTH, 32, HWDATA width.
- MASTER_WIDTH, 4, HMASTER width.
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (port 0 highest).

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  async active-low reset.
- sel_op0..2  in  1 each  port select from input-stage decoder.
- addr_op0..2  in  32 each  HADDR.
- trans_op0..2  in  2 each  HTRANS.
- write_op0..2  in  1 each  HWRITE.
- size_op0..2  in  3 each  HSIZE.
- burst_op0..2  in  3 each  HBURST.
- prot_op0..2  in  4 each  HPROT.
- master_op0..2  in  MASTER_WIDTH each  HMASTER.
- mastlock_op0..2  in  1 each  HMASTLOCK.
- wdata_op0..2  in  DATA_WIDTH each  HWDATA.
- active_op0..2  out  1 each  port owns current address phase.
- HREADYOUTM  in  1  slave HREADYOUT.
- HRESPM  in  1  slave HRESP (1 = ERROR).
- HSELM  out  1  slave select.
- HADDRM  out  32  slave address.
- HTRANSM  out  2  slave HTRANS.
- HWRITEM  out  1  slave HWRITE.
- HSIZEM  out  3  slave HSIZE.
- HBURSTM  out  3  slave HBURST.
- HPROTM  out  4  slave HPROT.
- HMASTERM  out  MASTER_WIDTH  slave HMASTER.
- HMASTLOCKM  out  1  slave HMASTLOCK.
- HWDATAM  out  DATA_WIDTH  slave write data.
- HREADYMUXM  out  1  HREADY to slave; equals HREADYOUTM.

Behaviour:
- Interface: clock HCLK; reset HRESETn, asynchronous, active-low.
- req_i = sel_op_i & (trans_op_i != IDLE).
- State registers, reset values:
  - last_port[1:0] = 2'd2, so port 0 has first priority after reset.
  - hold = 0.
  - hold_port = 0.
  - data_port = 0; data_vld = 0.
  - All updated only when HREADYOUTM = 1.
- Arbitration (combinational, zero latency):
  - If hold: addr_port = hold_port.
  - Else RR_EN = 1: first requesting port scanning (last_port+1, +2, +3) mod 3.
  - Else RR_EN = 0: lowest-index requester.
  - No requester and no hold: addr_vld = 0.
- Address outputs:
  - addr_vld = 1: mux from addr_port; HSELM = sel_op[addr_port].
  - Owner sel low: HTRANSM = IDLE.
  - addr_vld = 0: HSELM = 0, HTRANSM = IDLE, other controls driven 0.
- active_op_i = addr_vld & (addr_port == i), combinational; the decoder holds its transfer until it sees active.
- On HREADYOUTM = 1 with addr_vld:
  - last_port <= addr_port.
  - data_port <= addr_port.
  - data_vld <= (HTRANSM != IDLE).
- Hold set (on HREADYOUTM = 1), hold <= 1 and hold_port <= addr_port, when either:
  - HMASTLOCKM = 1 and HTRANSM != IDLE; or
  - HTRANSM = NONSEQ and HBURSTM != SINGLE.
- Hold clear (on HREADYOUTM = 1):
  - Owner presents IDLE with mastlock = 0.
  - Owner presents NONSEQ SINGLE unlocked.
  - Owner deasserts sel.
  - A new NONSEQ burst re-arms the hold.
- BUSY/SEQ from the owner keep the hold.
- Locked IDLE keeps the hold (locked sequence spans IDLE).
- HRESPM = 1 with HREADYOUTM = 0: no state change; the hold-release decision is taken on the completing cycle per the rules above.
- HWDATAM = wdata_op[data_port] when data_vld, else 0.
- HREADYMUXM = HREADYOUTM.
- HREADYOUTM = 0: address outputs stay on the current owner. Grant cannot move because state is frozen and inputs are stable per AHB.
- Simultaneous requests from all 3 ports with last_port = 0: port 1 wins, then 2, then 0.
- Reset mid-burst: all state returns to reset values immediately.
  - Outputs IDLE/0 combinationally from reset state.
  - active_op all 0 unless requests present.

Test Plan:
- Reset, then port0 NONSEQ SINGLE read 0x6004_0000 -> HTRANSM = NONSEQ, HADDRM = 0x6004_0000, active_op0 = 1 same cycle; next cycle data_port = 0.
- Ports 0/1/2 all request SINGLE writes back-to-back, HREADYOUTM = 1 -> grant order 0, 1, 2, 0; HWDATAM follows one cycle behind (0xA0, 0xA1, 0xA2).
- Port1 INCR4 (NONSEQ + 3 SEQ incl. 1 BUSY) while port0 requests:
  - active_op0 = 0 until port1 issues IDLE/NONSEQ SINGLE.
  - Then port0 granted next cycle.
- Port2 locked sequence (mastlock = 1, IDLE gap between two writes) with port0 requesting -> port2 retains grant across the IDLE; released after unlocked IDLE.
- Slave inserts 3 wait states (HREADYOUTM = 0), port1 raises request meanwhile -> HADDRM/HWDATAM stable, no grant change until HREADYOUTM = 1.
- Assert HRESETn = 0 mid-INCR4 -> HTRANSM = IDLE, HSELM = 0, hold cleared; after release port0 wins first.
